// File: rtl/sram_pio_pkg.sv
// Shared types and constants for the SRAM PIO access controller family.
package sram_pio_pkg;

    localparam int unsigned ADDR_W_DEF = 11;
    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned WAIT_MIN   = 1;
    localparam int unsigned WAIT_MAX   = 15;
    localparam int unsigned CNT_W      = 4;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        HOLD,
        DONE
    } state_e;

    function automatic logic wait_cycles_legal(input int unsigned w);
        return (w >= WAIT_MIN) && (w <= WAIT_MAX);
    endfunction

endpackage

// File: rtl/sram_pio_access_ctrl_if.sv
// PIO-side and SRAM-pad-side signals of the SRAM PIO access controller.
interface sram_pio_access_ctrl_if
    import sram_pio_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) ();

    logic [ADDR_W-1:0] pio_addr;
    logic [DATA_W-1:0] pio_wdata;
    logic              pio_start;
    logic              pio_we;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_dq_out;
    logic              sram_dq_oe;
    logic [DATA_W-1:0] sram_dq_in;
    logic              sram_ce_n;
    logic              sram_oe_n;
    logic              sram_we_n;

    // Controller view
    modport slave (
        input  pio_addr, pio_wdata, pio_start, pio_we, sram_dq_in,
        output rdata, busy, done, sram_addr, sram_dq_out, sram_dq_oe,
               sram_ce_n, sram_oe_n, sram_we_n
    );

    // PIO bank / SRAM pad view
    modport master (
        output pio_addr, pio_wdata, pio_start, pio_we, sram_dq_in,
        input  rdata, busy, done, sram_addr, sram_dq_out, sram_dq_oe,
               sram_ce_n, sram_oe_n, sram_we_n
    );

endinterface

// File: rtl/sram_pio_edge_det.sv
// Rising-edge detector for a software-driven PIO bit; the pulse is combinational.
module sram_pio_edge_det (
    input  logic clk,
    input  logic reset_n,
    input  logic sig_i,
    output logic rise_c_o
);

    logic sig_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_c_o = sig_i & ~sig_q;

endmodule

// File: rtl/sram_pio_access_ctrl.sv
// Turns PIO-written address/data/command into one timed async-SRAM cycle.
// Optional SRAM_PIO_AUTOINC_EN: repeated pio_addr launches use an incrementing pointer.
module sram_pio_access_ctrl
    import sram_pio_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    sram_pio_access_ctrl_if.slave  bus
);

    if (!wait_cycles_legal(WAIT_CYCLES)) begin : g_wait_range_err
        $error("WAIT_CYCLES must be within 1..15");
    end

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   dq_out_q, dq_out_d;
    logic                dq_oe_q, dq_oe_d;
    logic                ce_n_q, ce_n_d;
    logic                oe_n_q, oe_n_d;
    logic                we_n_q, we_n_d;

    logic                start_rise_c;
    logic                launch_c;
    logic [ADDR_W-1:0]   launch_addr_c;

    sram_pio_edge_det u_start_edge (
        .clk      (clk),
        .reset_n  (reset_n),
        .sig_i    (bus.pio_start),
        .rise_c_o (start_rise_c)
    );

    assign launch_c = start_rise_c && (state_q == IDLE);

`ifdef SRAM_PIO_AUTOINC_EN
    logic [ADDR_W-1:0] last_pio_addr_q;
    logic              last_vld_q;

    // addr_q only changes on launch, so it doubles as the burst pointer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_pio_addr_q <= '0;
            last_vld_q      <= 1'b0;
        end else if (launch_c) begin
            last_pio_addr_q <= bus.pio_addr;
            last_vld_q      <= 1'b1;
        end
    end

    assign launch_addr_c = (last_vld_q && (bus.pio_addr == last_pio_addr_q))
                         ? addr_q + ADDR_W'(1) : bus.pio_addr;
`else
    assign launch_addr_c = bus.pio_addr;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            rdata_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            addr_q   <= '0;
            dq_out_q <= '0;
            dq_oe_q  <= 1'b0;
            ce_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            we_n_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            rdata_q  <= rdata_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            addr_q   <= addr_d;
            dq_out_q <= dq_out_d;
            dq_oe_q  <= dq_oe_d;
            ce_n_q   <= ce_n_d;
            oe_n_q   <= oe_n_d;
            we_n_q   <= we_n_d;
        end
    end

    // Strobes are computed one state ahead so each is a clean flop output
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        rdata_d  = rdata_q;
        busy_d   = busy_q;
        done_d   = done_q;
        addr_d   = addr_q;
        dq_out_d = dq_out_q;
        dq_oe_d  = dq_oe_q;
        ce_n_d   = ce_n_q;
        oe_n_d   = oe_n_q;
        we_n_d   = we_n_q;

        unique case (state_q)
            IDLE: begin
                if (launch_c) begin
                    state_d = SETUP;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    we_d    = bus.pio_we;
                    addr_d  = launch_addr_c;
                    ce_n_d  = 1'b0;
                    oe_n_d  = bus.pio_we;
                    dq_oe_d = bus.pio_we;
                    if (bus.pio_we) begin
                        dq_out_d = bus.pio_wdata;
                    end
                end
            end
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                we_n_d  = ~we_q;
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = HOLD;
                    we_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    if (!we_q) begin
                        rdata_d = bus.sram_dq_in;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HOLD: begin
                state_d = DONE;
                ce_n_d  = 1'b1;
                dq_oe_d = 1'b0;
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.rdata       = rdata_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.sram_addr   = addr_q;
    assign bus.sram_dq_out = dq_out_q;
    assign bus.sram_dq_oe  = dq_oe_q;
    assign bus.sram_ce_n   = ce_n_q;
    assign bus.sram_oe_n   = oe_n_q;
    assign bus.sram_we_n   = we_n_q;

endmodule
